// File: rtl/dsss_spread_gen.sv
// dsss_spread_gen: direct-sequence spreader with an internal Fibonacci LFSR.
//
// Info bits are taken over a valid/ready handshake. Each bit is spread over
// SF chips. Each chip is emitted as a signed NRZ code of +AMP or -AMP.
// The PN sequence runs continuously across bits. Only reset reloads the seed.
//
// Ports:
//   clk_cx      chip-rate clock
//   rst_n       asynchronous active-low reset
//   en          clock enable; 0 freezes every register, outputs included
//   mode        0 = data spreading, 1 = pilot (PN only); latched per bit
//   info        info bit
//   info_valid  info is valid
//   ready_info  bit accepted this cycle if info_valid is high (combinational)
//   code        signed chip code, CODE_W bits
//   flag_code   code is valid (qualify with en downstream)
//   bit_start   marks the first chip of each bit
//   pn_wrap     marks the last chip of each PN period
module dsss_spread_gen #(
  parameter int                  PN_ORDER = 5,
  parameter logic [PN_ORDER-1:0] PN_TAPS  = 5'b00101,
  parameter logic [PN_ORDER-1:0] PN_SEED  = 5'b00001,
  parameter int                  SF       = 31,
  parameter int                  CODE_W   = 3,
  parameter int                  AMP      = 3
) (
  input  logic                     clk_cx,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     info,
  input  logic                     info_valid,
  output logic                     ready_info,
  output logic signed [CODE_W-1:0] code,
  output logic                     flag_code,
  output logic                     bit_start,
  output logic                     pn_wrap
);

  localparam int                       CNT_W = $clog2(SF + 1);
  localparam logic [CNT_W-1:0]         LAST  = CNT_W'(SF - 1);
  localparam logic signed [CODE_W-1:0] AMP_S = CODE_W'(AMP);

  if (PN_ORDER < 2 || PN_ORDER > 16) begin : g_bad_order
    $error("dsss_spread_gen: PN_ORDER must be in 2..16");
  end
  if (PN_SEED == '0) begin : g_bad_seed
    $error("dsss_spread_gen: PN_SEED must be non-zero");
  end
  if (SF < 1 || SF > 65535) begin : g_bad_sf
    $error("dsss_spread_gen: SF must be in 1..65535");
  end
  if (AMP < 1 || AMP > (2 ** (CODE_W - 1)) - 1) begin : g_bad_amp
    $error("dsss_spread_gen: AMP must be in 1..2^(CODE_W-1)-1");
  end

  // The chip value 1 maps to -AMP and 0 maps to +AMP. The result is always in range.
  function automatic logic signed [CODE_W-1:0] chip_code(input logic chip);
    chip_code = chip ? -AMP_S : AMP_S;
  endfunction

  typedef enum logic {IDLE, SPREAD} state_t;

  state_t               state, state_next;
  logic [PN_ORDER-1:0]  lfsr, lfsr_next, lfsr_step;
  logic [CNT_W-1:0]     chip_cnt, cnt_next;
  logic                 info_q, info_next;
  logic                 mode_q, mode_next;
  logic signed [CODE_W-1:0] code_next;
  logic                 flag_next, bs_next, wrap_next;
  logic                 accept;

  always_comb begin
    lfsr_step  = {^(lfsr & PN_TAPS), lfsr[PN_ORDER-1:1]};
    // chip_cnt indexes the chip currently on the outputs. On the last chip
    // the block accepts the next bit, so consecutive bits have no gap.
    ready_info = en && ((state == IDLE) || (state == SPREAD && chip_cnt == LAST));
    accept     = info_valid && ready_info;

    state_next = state;
    lfsr_next  = lfsr;
    cnt_next   = chip_cnt;
    info_next  = info_q;
    mode_next  = mode_q;
    code_next  = code;
    flag_next  = flag_code;
    bs_next    = bit_start;
    wrap_next  = pn_wrap;

    if (accept) begin
      // The first chip of a new bit is registered on the acceptance edge.
      // That chip uses the incoming info and mode directly.
      state_next = SPREAD;
      cnt_next   = '0;
      info_next  = info;
      mode_next  = mode;
      code_next  = chip_code(lfsr[0] ^ (info & ~mode));
      flag_next  = 1'b1;
      bs_next    = 1'b1;
      wrap_next  = (lfsr_step == PN_SEED);
      lfsr_next  = lfsr_step;
    end else if (en) begin
      if (state == SPREAD && chip_cnt != LAST) begin
        cnt_next  = chip_cnt + 1'b1;
        code_next = chip_code(lfsr[0] ^ (info_q & ~mode_q));
        flag_next = 1'b1;
        bs_next   = 1'b0;
        wrap_next = (lfsr_step == PN_SEED);
        lfsr_next = lfsr_step;
      end else begin
        state_next = IDLE;
        code_next  = '0;
        flag_next  = 1'b0;
        bs_next    = 1'b0;
        wrap_next  = 1'b0;
      end
    end
  end

  // Register stage: the FSM, PN state and the registered chip outputs.
  always_ff @(posedge clk_cx or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= PN_SEED;
      chip_cnt  <= '0;
      info_q    <= 1'b0;
      mode_q    <= 1'b0;
      code      <= '0;
      flag_code <= 1'b0;
      bit_start <= 1'b0;
      pn_wrap   <= 1'b0;
    end else begin
      state     <= state_next;
      lfsr      <= lfsr_next;
      chip_cnt  <= cnt_next;
      info_q    <= info_next;
      mode_q    <= mode_next;
      code      <= code_next;
      flag_code <= flag_next;
      bit_start <= bs_next;
      pn_wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_dsss_spread_gen.sv
module tb_dsss_spread_gen;

  logic clk_cx = 1'b0;
  always #5 clk_cx = ~clk_cx;

  logic rst_n, en, mode, info, info_valid;
  logic ready_info, flag_code, bit_start, pn_wrap;
  logic signed [2:0] code;

  logic info6, valid6;
  logic ready6, flag6, bs6, wrap6;
  logic signed [2:0] code6;

  dsss_spread_gen dut (
    .clk_cx(clk_cx), .rst_n(rst_n), .en(en), .mode(mode), .info(info),
    .info_valid(info_valid), .ready_info(ready_info), .code(code),
    .flag_code(flag_code), .bit_start(bit_start), .pn_wrap(pn_wrap)
  );

  dsss_spread_gen #(
    .PN_ORDER(3), .PN_TAPS(3'b011), .PN_SEED(3'b001), .SF(4), .CODE_W(3), .AMP(3)
  ) u6 (
    .clk_cx(clk_cx), .rst_n(rst_n), .en(en), .mode(mode), .info(info6),
    .info_valid(valid6), .ready_info(ready6), .code(code6),
    .flag_code(flag6), .bit_start(bs6), .pn_wrap(wrap6)
  );

  // Hand-derived PN chips (lfsr[0] per emitted chip) for the two configurations.
  bit pn31 [31] = '{1,0,0,0,0,1,0,0,1,0,1,1,0,0,1,1,1,1,1,0,0,0,1,1,0,1,1,1,0,1,0};
  bit pn7  [12] = '{1,0,0,1,0,1,1,1,0,0,1,0};

  int checks = 0;
  int errors = 0;
  int sum;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_cx);
    #1;
  endtask

  task automatic exp_chip(input string tag, input bit chip, input bit bs,
                          input bit wr, input bit rdy);
    chk({tag, ".code"}, code, chip ? -3 : 3);
    chk({tag, ".flag"}, flag_code, 1);
    chk({tag, ".bit_start"}, bit_start, bs);
    chk({tag, ".pn_wrap"}, pn_wrap, wr);
    chk({tag, ".ready"}, ready_info, rdy);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".code"}, code, 0);
    chk({tag, ".flag"}, flag_code, 0);
    chk({tag, ".bit_start"}, bit_start, 0);
    chk({tag, ".pn_wrap"}, pn_wrap, 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; info = 1'b0; info_valid = 1'b0;
    info6 = 1'b0; valid6 = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: single info=0 bit
    do_reset;
    exp_idle("s1.reset");
    chk("s1.ready_idle", ready_info, 1);
    info = 1'b0; info_valid = 1'b1;
    tick;
    info_valid = 1'b0;
    sum = 0;
    for (int k = 0; k < 31; k++) begin
      exp_chip($sformatf("s1.c%0d", k), pn31[k], k == 0, k == 30, k == 30);
      sum += int'(code);
      tick;
    end
    exp_idle("s1.end");
    chk("s1.sum", sum, -3);

    // 2: two back-to-back bits, info 0 then 1
    do_reset;
    info = 1'b0; info_valid = 1'b1;
    chk("s2.ready_idle", ready_info, 1);
    tick;
    for (int k = 0; k < 31; k++) begin
      exp_chip($sformatf("s2.b1c%0d", k), pn31[k], k == 0, k == 30, k == 30);
      if (k == 30) info = 1'b1;
      tick;
    end
    for (int k = 0; k < 31; k++) begin
      exp_chip($sformatf("s2.b2c%0d", k), pn31[k] ^ 1'b1, k == 0, k == 30, k == 30);
      if (k == 0) info_valid = 1'b0;
      tick;
    end
    exp_idle("s2.end");

    // 3: pilot mode ignores info; mode/info changes mid-bit have no effect
    do_reset;
    mode = 1'b1; info = 1'b1; info_valid = 1'b1;
    tick;
    info_valid = 1'b0; mode = 1'b0; info = 1'b1;
    for (int k = 0; k < 31; k++) begin
      exp_chip($sformatf("s3.c%0d", k), pn31[k], k == 0, k == 30, k == 30);
      tick;
    end
    exp_idle("s3.end");

    // 4: en low for 5 cycles while chip 10 is on the outputs
    do_reset;
    info = 1'b0; info_valid = 1'b1;
    tick;
    info_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_chip($sformatf("s4.c%0d", k), pn31[k], k == 0, 1'b0, 1'b0);
      if (k < 9) tick;
    end
    en = 1'b0; info_valid = 1'b1;
    chk("s4.ready_en0", ready_info, 0);
    for (int h = 0; h < 5; h++) begin
      tick;
      chk($sformatf("s4.hold%0d.code", h), code, pn31[9] ? -3 : 3);
      chk($sformatf("s4.hold%0d.flag", h), flag_code, 1);
      chk($sformatf("s4.hold%0d.ready", h), ready_info, 0);
      chk($sformatf("s4.hold%0d.bit_start", h), bit_start, 0);
    end
    info_valid = 1'b0; en = 1'b1;
    tick;
    for (int k = 10; k < 31; k++) begin
      exp_chip($sformatf("s4.c%0d", k), pn31[k], 1'b0, k == 30, k == 30);
      tick;
    end
    exp_idle("s4.end");

    // 5: asynchronous reset during chip 12, then restart from the seed
    do_reset;
    info = 1'b0; info_valid = 1'b1;
    tick;
    info_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp_chip($sformatf("s5.c%0d", k), pn31[k], k == 0, 1'b0, 1'b0);
      if (k < 11) tick;
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_idle("s5.async");
    tick;
    tick;
    tick;
    rst_n = 1'b1;
    exp_idle("s5.released");
    chk("s5.ready", ready_info, 1);
    info = 1'b0; info_valid = 1'b1;
    tick;
    info_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_chip($sformatf("s5.r%0d", k), pn31[k], k == 0, 1'b0, 1'b0);
      tick;
    end

    // 6: N=3 LFSR, SF=4, three contiguous info=0 bits
    do_reset;
    info6 = 1'b0; valid6 = 1'b1;
    chk("s6.ready_idle", ready6, 1);
    tick;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("s6.c%0d.code", k), code6, pn7[k] ? -3 : 3);
      chk($sformatf("s6.c%0d.flag", k), flag6, 1);
      chk($sformatf("s6.c%0d.bit_start", k), bs6, (k % 4) == 0);
      chk($sformatf("s6.c%0d.pn_wrap", k), wrap6, k == 6);
      chk($sformatf("s6.c%0d.ready", k), ready6, (k % 4) == 3);
      if (k == 8) valid6 = 1'b0;
      tick;
    end
    chk("s6.end.code", code6, 0);
    chk("s6.end.flag", flag6, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
